// File: rtl/ucie_ctl_pkg.sv
// ---------------------------------------------------------------------------
// ucie_ctl_pkg
// Shared definitions for the UCIe controller TX and RX paths.
//   - REQ_* : link state request codes carried on *_state_request
//   - tx_state_t : TX FSM state encoding, also exported on o_tx_state
//   - req_is_teardown / req_is_low_power : request classification helpers
// ---------------------------------------------------------------------------
package ucie_ctl_pkg;

    localparam logic [3:0] REQ_NOP       = 4'b0000;
    localparam logic [3:0] REQ_ACTIVE    = 4'b0001;
    localparam logic [3:0] REQ_L1        = 4'b0100;
    localparam logic [3:0] REQ_L2        = 4'b1000;
    localparam logic [3:0] REQ_LINKRESET = 4'b1001;
    localparam logic [3:0] REQ_DISABLE   = 4'b1100;

    typedef enum logic [1:0] {
        TX_IDLE   = 2'b00,
        TX_ACTIVE = 2'b01,
        TX_DRAIN  = 2'b10,
        TX_ERROR  = 2'b11
    } tx_state_t;

    // LINKRESET and DISABLE both tear the path down and discard buffered flits.
    function automatic logic req_is_teardown(input logic [3:0] req);
        return (req == REQ_LINKRESET) || (req == REQ_DISABLE);
    endfunction

    function automatic logic req_is_low_power(input logic [3:0] req);
        return (req == REQ_L1) || (req == REQ_L2);
    endfunction

endpackage

// File: rtl/ucie_ctl_tx_fifo.sv
// ---------------------------------------------------------------------------
// ucie_ctl_tx_fifo
// Small synchronous FIFO buffering TX flits between FDI and RDI.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   push, wr_data  write wr_data at the tail (ignored when full)
//   pop            drop the head entry (ignored when empty)
//   flush          discard all entries; wins over push/pop
//   head_data      combinational head entry, 0 when empty
//   full, empty    occupancy flags
//   count          number of entries held (AW+1 bits)
// ---------------------------------------------------------------------------
module ucie_ctl_tx_fifo #(
    parameter  int NBYTES = 8,
    parameter  int DEPTH  = 4,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [NBYTES*8-1:0]   wr_data,
    output logic [NBYTES*8-1:0]   head_data,
    output logic                  full,
    output logic                  empty,
    output logic [AW:0]           count
);

    logic [NBYTES*8-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full && !flush;
    assign do_pop    = pop && !empty && !flush;
    assign head_data = empty ? '0 : mem[rd_ptr];

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ucie_ctl_tx_path.sv
// ---------------------------------------------------------------------------
// ucie_ctl_tx_path
// TX direction of the UCIe controller: FDI flits are buffered and forwarded
// to the RDI, gated by a link-state FSM.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_state_request       requested link state (REQ_* codes, others = NOP)
//   i_fdi_lp_data/valid   flit from protocol layer
//   o_fdi_pl_trdy         flit accepted this cycle when valid is high
//   o_rdi_lp_data/valid   head flit towards the adapter (data 0 when empty)
//   i_rdi_pl_trdy         adapter accepts the head flit
//   o_overflow_detected   sticky: flit offered while full in ACTIVE
//   o_buffer_empty        FIFO holds no entries
//   o_tx_state            current FSM state
//
// state     | meaning
// ----------+--------------------------------------------------------------
// TX_IDLE   | link down, FIFO held empty, nothing accepted or sent
// TX_ACTIVE | accept from FDI while not full, forward to RDI
// TX_DRAIN  | low-power entry: stop accepting, forward what remains
// TX_ERROR  | overflow seen: both sides stalled until LINKRESET/DISABLE
// ---------------------------------------------------------------------------
module ucie_ctl_tx_path
    import ucie_ctl_pkg::*;
#(
    parameter  int NBYTES = 8,
    parameter  int DEPTH  = 4,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [3:0]            i_state_request,
    input  logic [NBYTES*8-1:0]   i_fdi_lp_data,
    input  logic                  i_fdi_lp_valid,
    output logic                  o_fdi_pl_trdy,
    output logic [NBYTES*8-1:0]   o_rdi_lp_data,
    output logic                  o_rdi_lp_valid,
    input  logic                  i_rdi_pl_trdy,
    output logic                  o_overflow_detected,
    output logic                  o_buffer_empty,
    output logic [1:0]            o_tx_state
);

    tx_state_t   state;
    logic        full;
    logic        empty;
    logic [AW:0] count;
    logic        push;
    logic        pop;
    logic        flush;
    logic        teardown;
    logic        ovf_event;

    assign teardown       = req_is_teardown(i_state_request);
    assign o_fdi_pl_trdy  = (state == TX_ACTIVE) && !full;
    assign o_rdi_lp_valid = !empty && ((state == TX_ACTIVE) || (state == TX_DRAIN));
    assign push           = i_fdi_lp_valid && o_fdi_pl_trdy;
    assign pop            = o_rdi_lp_valid && i_rdi_pl_trdy;
    assign ovf_event      = (state == TX_ACTIVE) && i_fdi_lp_valid && full;
    // IDLE keeps the FIFO clear; a teardown request discards from any state.
    assign flush          = (state == TX_IDLE) || teardown;
    assign o_buffer_empty = empty;
    assign o_tx_state     = state;

    ucie_ctl_tx_fifo #(
        .NBYTES (NBYTES),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .wr_data   (i_fdi_lp_data),
        .head_data (o_rdi_lp_data),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state               <= TX_IDLE;
            o_overflow_detected <= 1'b0;
        end else begin
            if (ovf_event) begin
                o_overflow_detected <= 1'b1;
            end
            unique case (state)
                TX_IDLE: begin
                    if (i_state_request == REQ_ACTIVE) begin
                        state <= TX_ACTIVE;
                    end
                end
                TX_ACTIVE: begin
                    if (teardown) begin
                        state <= TX_IDLE;
                    end else if (ovf_event) begin
                        state <= TX_ERROR;
                    end else if (req_is_low_power(i_state_request)) begin
                        state <= TX_DRAIN;
                    end
                end
                TX_DRAIN: begin
                    if (teardown) begin
                        state <= TX_IDLE;
                    end else if (empty || (count == (AW+1)'(1) && pop)) begin
                        state <= TX_IDLE;
                    end else if (i_state_request == REQ_ACTIVE) begin
                        state <= TX_ACTIVE;
                    end
                end
                TX_ERROR: begin
                    if (teardown) begin
                        state               <= TX_IDLE;
                        o_overflow_detected <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
